// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-stage constants: instruction width, default PC width and the NOP word.
package fetch_prefetch_pkg;

  localparam int unsigned PC_W_DEF  = 16;
  localparam int unsigned INSTR_W   = 32;
  // LLB R0,#0 -- harmless filler the decoder sees while the prefetch queue is empty
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h5800_0000;

endpackage

// File: rtl/fetch_prefetch_pf_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits with push, pop, clear and occupancy count.
module pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and occupancy; clear wins over push/pop, pointers wrap mod DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with prefetch queue: issues reads, buffers words, squashes stale responses on redirect.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEF,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    dst_ID_EX,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_rvalid,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    nxt_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = INSTR_W + PC_W;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  expect_pc_q, expect_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic [ENT_W-1:0] fifo_rdata, fifo_wdata;
  logic             push, pop;
  logic [SUM_W-1:0] occupancy;

  // Every issued read holds a reserved FIFO slot until its word is popped or discarded
  assign occupancy = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
  assign im_req    = !rst && !flow_change_ID_EX && (occupancy < SUM_W'(DEPTH));
  assign im_addr   = fetch_pc_q;

  assign push       = im_rvalid && (discard_q == '0) && !flow_change_ID_EX;
  assign pop        = !stall_IM_ID && !fifo_empty && !flow_change_ID_EX;
  // expect_pc tracks the address of the next live response, so its entry stores that address + 1
  assign fifo_wdata = {im_rdata, expect_pc_q + PC_W'(1)};

  pf_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flow_change_ID_EX),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // PC and in-flight bookkeeping; a redirect turns every live in-flight read into a discard
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    expect_pc_d   = expect_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (flow_change_ID_EX) begin
      fetch_pc_d    = dst_ID_EX;
      expect_pc_d   = dst_ID_EX;
      discard_d     = outstanding_q - CNT_W'(im_rvalid);
      outstanding_d = outstanding_q - CNT_W'(im_rvalid);
    end else begin
      if (im_req) fetch_pc_d  = fetch_pc_q + PC_W'(1);
      if (push)   expect_pc_d = expect_pc_q + PC_W'(1);
      if (im_rvalid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      outstanding_d = outstanding_q + CNT_W'(im_req) - CNT_W'(im_rvalid);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      expect_pc_q   <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      expect_pc_q   <= expect_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // A response arriving into a full queue means the slot reservation broke
  always @(posedge clk) begin
    if (!rst && im_rvalid) assert (!fifo_full);
  end

  assign instr  = fifo_empty ? NOP_INSTR   : fifo_rdata[ENT_W-1 -: INSTR_W];
  assign nxt_pc = fifo_empty ? expect_pc_q : fifo_rdata[PC_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: memory model with per-request latency, expected PC stream queue.
module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  logic        clk, rst, stall_IM_ID, flow_change_ID_EX;
  logic [15:0] dst_ID_EX, im_addr, nxt_pc;
  logic        im_req, im_rvalid;
  logic [31:0] im_rdata, instr;

  fetch_prefetch #(.PC_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_IM_ID(stall_IM_ID), .flow_change_ID_EX(flow_change_ID_EX),
    .dst_ID_EX(dst_ID_EX), .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .instr(instr), .nxt_pc(nxt_pc)
  );

  typedef struct { int due; logic [15:0] addr; } req_t;

  int          checks = 0;
  int          failures = 0;
  int          lat_mode = 1;   // 0: random 1..5 per request, else fixed latency
  int          cyc = 0;
  int          last_due = 0;
  req_t        pend[$];
  logic [15:0] exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [15:0] a);
    return {16'hA5C3, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic restart(input logic [15:0] t);
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(t + 16'(i));
  endtask

  // Memory model: captures the request before the edge, answers in order after its latency
  initial begin
    logic        req_s;
    logic [15:0] addr_s;
    req_t        r;
    int          l;
    im_rvalid = 1'b0;
    im_rdata  = '0;
    forever begin
      @(negedge clk);
      req_s  = im_req;
      addr_s = im_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend.delete();
        im_rvalid = 1'b0;
        im_rdata  = '0;
        continue;
      end
      if (im_rvalid) void'(pend.pop_front());
      if (req_s) begin
        l = (lat_mode == 0) ? int'($urandom_range(1, 5)) : lat_mode;
        r.due  = (cyc + l <= last_due) ? last_due + 1 : cyc + l;
        r.addr = addr_s;
        last_due = r.due;
        pend.push_back(r);
      end
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        im_rvalid = 1'b1;
        im_rdata  = word(pend[0].addr);
      end else begin
        im_rvalid = 1'b0;
        im_rdata  = '0;
      end
    end
  end

  // Monitor: every consumed instruction must be the next expected program-order word
  initial begin
    logic [15:0] pc, npc;
    forever begin
      @(negedge clk);
      if (!rst && !stall_IM_ID && !flow_change_ID_EX && instr != NOP_INSTR) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected: got %h expected nothing", instr);
        end else begin
          pc  = exp_q.pop_front();
          npc = pc + 16'd1;
          chk("stream_instr", instr, word(pc));
          chk("stream_npc", 32'(nxt_pc), 32'(npc));
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [15:0] h, h1;
    int          exp_disc;
    bit          found;
    rst = 1'b1; stall_IM_ID = 1'b0; flow_change_ID_EX = 1'b0; dst_ID_EX = '0;

    // Reset values
    tick(3); #1;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_nxt_pc", 32'(nxt_pc), 32'd0);

    // Release, L=1: consecutive addresses, word0 visible two cycles later
    tick(1); rst = 1'b0; restart(16'h0000); #1;
    chk("start_im_req", 32'(im_req), 32'd1);
    chk("start_im_addr", 32'(im_addr), 32'd0);
    for (int k = 1; k < 6; k++) begin
      tick(1); #1;
      chk("seq_im_req", 32'(im_req), 32'd1);
      chk("seq_im_addr", 32'(im_addr), 32'(k));
      if (k == 2) begin
        chk("first_instr", instr, word(16'h0000));
        chk("first_nxt_pc", 32'(nxt_pc), 32'd1);
      end
    end
    tick(10);

    // Stall held 6 cycles: output frozen, issue stops once 4 slots are taken
    stall_IM_ID = 1'b1; #1;
    h  = exp_q[0];
    h1 = h + 16'd1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin tick(1); #1; end
      chk("stall_instr", instr, word(h));
      chk("stall_nxt_pc", 32'(nxt_pc), 32'(h1));
    end
    chk("stall_im_req", 32'(im_req), 32'd0);
    stall_IM_ID = 1'b0;
    tick(10);

    // Redirect to 0x0040 with two reads in flight at L=3
    lat_mode = 3;
    tick(12);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend.size() == 2) found = 1'b1;
      else tick(1);
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_two_outstanding: got %0d expected 2", pend.size());
    end
    flow_change_ID_EX = 1'b1; dst_ID_EX = 16'h0040; restart(16'h0040);
    tick(1); flow_change_ID_EX = 1'b0; #1;
    for (int k = 1; k <= 4; k++) begin
      chk("redir_nop", instr, NOP_INSTR);
      tick(1); #1;
    end
    chk("redir_instr", instr, word(16'h0040));
    chk("redir_nxt_pc", 32'(nxt_pc), 32'h41);
    tick(10);

    // Redirect coinciding with a response while stalled
    lat_mode = 2;
    tick(10);
    stall_IM_ID = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1);
      if (im_rvalid) found = 1'b1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_rvalid: got 0 expected 1");
    end
    exp_disc = pend.size() - 1;
    flow_change_ID_EX = 1'b1; dst_ID_EX = 16'h0100; restart(16'h0100);
    tick(1); flow_change_ID_EX = 1'b0; #1;
    chk("fc_rv_fifo_count", 32'(dut.fifo_count), 32'd0);
    chk("fc_rv_discard", 32'(dut.discard_q), 32'(exp_disc));
    chk("fc_rv_fetch_pc", 32'(im_addr), 32'h100);
    stall_IM_ID = 1'b0;
    tick(10);

    // Reset pulse with a full FIFO
    lat_mode = 1;
    tick(5);
    stall_IM_ID = 1'b1;
    tick(8); #1;
    chk("full_before_rst", 32'(dut.fifo_count), 32'd4);
    rst = 1'b1; exp_q.delete(); #1;
    chk("mid_rst_im_req", 32'(im_req), 32'd0);
    chk("mid_rst_im_addr", 32'(im_addr), 32'd0);
    chk("mid_rst_instr", instr, NOP_INSTR);
    chk("mid_rst_nxt_pc", 32'(nxt_pc), 32'd0);
    chk("mid_rst_fifo", 32'(dut.fifo_count), 32'd0);
    stall_IM_ID = 1'b0;
    tick(2); rst = 1'b0; restart(16'h0000); #1;
    chk("restart_im_req", 32'(im_req), 32'd1);
    chk("restart_im_addr", 32'(im_addr), 32'd0);

    // Mixed phase: random latency, stalls and redirects against the expected stream
    lat_mode = 0;
    for (int k = 0; k < 400; k++) begin
      tick(1);
      stall_IM_ID = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 31) == 0) begin
        flow_change_ID_EX = 1'b1;
        dst_ID_EX = 16'($urandom_range(0, 65535));
        restart(dst_ID_EX);
      end else begin
        flow_change_ID_EX = 1'b0;
      end
    end
    tick(1);
    stall_IM_ID = 1'b0; flow_change_ID_EX = 1'b0;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
